// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared field widths, time bundle and load saturation.
// Optional feature macro: STOPWATCH_DAY_COUNT_EN (adds day output in top).
package stopwatch_pkg;

  localparam int HOUR_W = 6;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MS_W   = 10;

  localparam logic [MS_W-1:0]  MS_MAX = 10'd999;
  localparam logic [SEC_W-1:0] SM_MAX = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic [MS_W-1:0]   m_sec;
  } time_t;

  function automatic time_t saturate_time(
    input time_t             t,
    input logic [HOUR_W-1:0] h_max
  );
    time_t r;
    r = t;
    if (t.hour > h_max)    r.hour   = h_max;
    if (t.minute > SM_MAX) r.minute = SM_MAX;
    if (t.second > SM_MAX) r.second = SM_MAX;
    if (t.m_sec > MS_MAX)  r.m_sec  = MS_MAX;
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_lap_fifo.sv
// lap_fifo: first-word-fall-through split FIFO with sticky overflow.
// Optional feature macro: none (see STOPWATCH_DAY_COUNT_EN in top).
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = time_t
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  logic ovf_clr,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty,
  output logic overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? T'('0) : mem[rd_q];

  // storage and pointers; a pop frees room for a same-cycle push
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_q] <= din;
        wr_q      <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // sticky drop flag: push into a full FIFO with no pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     overflow <= 1'b0;
    else if (ovf_clr)                 overflow <= 1'b0;
    else if (push & full & ~do_pop)   overflow <= 1'b1;
  end

endmodule

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: HH:MM:SS.mmm up/down stopwatch with lap FIFO.
// Optional feature macro: STOPWATCH_DAY_COUNT_EN adds day[7:0].
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int LAP_DEPTH   = 4,
  parameter int HOUR_MODULO = 24
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        clear,
  input  logic        mode_down,
  input  logic        load,
  input  logic [17:0] load_epoch,
  input  logic [9:0]  load_m_epoch,
  input  logic        lap,
  output logic [17:0] epoch,
  output logic [9:0]  m_epoch,
  output logic        wrap,
  output logic        done,
  output logic [17:0] lap_epoch,
  output logic [9:0]  lap_m_epoch,
  output logic        lap_valid,
  input  logic        lap_ready,
  output logic        lap_overflow
`ifdef STOPWATCH_DAY_COUNT_EN
  ,
  output logic [7:0]  day
`endif
);

  localparam int PRE_N = CLK_FREQ_HZ / 1000;
  localparam int PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRE_N - 1);
  localparam logic [HOUR_W-1:0] H_MAX   = HOUR_W'(HOUR_MODULO - 1);

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  time_t            time_q;
  time_t            time_d;
  time_t            t_inc;
  time_t            t_dec;
  time_t            load_t;
  time_t            head;
  logic             inc_wrap;
  logic             at_zero;
  logic             wrap_d;
  logic             done_d;
  logic             unused_full;
  logic             lap_empty;

`ifdef STOPWATCH_DAY_COUNT_EN
  logic [7:0] day_q;
  logic [7:0] day_d;
  logic       dec_borrow;
  assign day = day_q;
`endif

  assign tick   = run & (pre_q == PRE_MAX);
  assign load_t = time_t'({load_epoch, load_m_epoch});

`ifdef STOPWATCH_DAY_COUNT_EN
  assign at_zero = (time_q == '0) & (day_q == '0);
`else
  assign at_zero = (time_q == '0);
`endif

  // prescaler: runs only while run=1, restarts on clear/load
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         pre_q <= '0;
    else if (clear|load)  pre_q <= '0;
    else if (tick)        pre_q <= '0;
    else if (run)         pre_q <= pre_q + 1'b1;
  end

  // up-count carry chain, carries judged on pre-increment values
  always_comb begin
    t_inc    = time_q;
    inc_wrap = 1'b0;
    if (time_q.m_sec != MS_MAX) begin
      t_inc.m_sec = time_q.m_sec + 1'b1;
    end else begin
      t_inc.m_sec = '0;
      if (time_q.second != SM_MAX) begin
        t_inc.second = time_q.second + 1'b1;
      end else begin
        t_inc.second = '0;
        if (time_q.minute != SM_MAX) begin
          t_inc.minute = time_q.minute + 1'b1;
        end else begin
          t_inc.minute = '0;
          if (time_q.hour != H_MAX) begin
            t_inc.hour = time_q.hour + 1'b1;
          end else begin
            t_inc.hour = '0;
            inc_wrap   = 1'b1;
          end
        end
      end
    end
  end

  // down-count borrow chain mirroring the up chain
  always_comb begin
    t_dec = time_q;
`ifdef STOPWATCH_DAY_COUNT_EN
    dec_borrow = 1'b0;
`endif
    if (time_q.m_sec != '0) begin
      t_dec.m_sec = time_q.m_sec - 1'b1;
    end else begin
      t_dec.m_sec = MS_MAX;
      if (time_q.second != '0) begin
        t_dec.second = time_q.second - 1'b1;
      end else begin
        t_dec.second = SM_MAX;
        if (time_q.minute != '0) begin
          t_dec.minute = time_q.minute - 1'b1;
        end else begin
          t_dec.minute = SM_MAX;
          if (time_q.hour != '0) begin
            t_dec.hour = time_q.hour - 1'b1;
          end else begin
            t_dec.hour = H_MAX;
`ifdef STOPWATCH_DAY_COUNT_EN
            dec_borrow = 1'b1;
`endif
          end
        end
      end
    end
  end

  // next time: clear beats load beats tick; down mode stops at zero
  always_comb begin
    time_d = time_q;
    wrap_d = 1'b0;
    done_d = done;
`ifdef STOPWATCH_DAY_COUNT_EN
    day_d  = day_q;
`endif
    if (clear) begin
      time_d = '0;
      done_d = 1'b0;
`ifdef STOPWATCH_DAY_COUNT_EN
      day_d  = '0;
`endif
    end else if (load) begin
      time_d = saturate_time(load_t, H_MAX);
      done_d = 1'b0;
`ifdef STOPWATCH_DAY_COUNT_EN
      day_d  = '0;
`endif
    end else if (tick) begin
      if (!mode_down) begin
        time_d = t_inc;
        wrap_d = inc_wrap;
`ifdef STOPWATCH_DAY_COUNT_EN
        if (inc_wrap) day_d = day_q + 8'd1;
`endif
      end else if (!done) begin
        if (at_zero) begin
          done_d = 1'b1;
        end else begin
          time_d = t_dec;
`ifdef STOPWATCH_DAY_COUNT_EN
          if (dec_borrow) day_d = day_q - 8'd1;
`endif
        end
      end
    end
  end

  // time and status registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      time_q <= '0;
      wrap   <= 1'b0;
      done   <= 1'b0;
    end else begin
      time_q <= time_d;
      wrap   <= wrap_d;
      done   <= done_d;
    end
  end

`ifdef STOPWATCH_DAY_COUNT_EN
  // day counter extends the time chain above hours
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) day_q <= '0;
    else          day_q <= day_d;
  end
`endif

  assign epoch   = {time_q.hour, time_q.minute, time_q.second};
  assign m_epoch = time_q.m_sec;

  lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .T     (time_t)
  ) u_lap_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (lap),
    .pop      (lap_ready),
    .ovf_clr  (clear),
    .din      (time_q),
    .dout     (head),
    .full     (unused_full),
    .empty    (lap_empty),
    .overflow (lap_overflow)
  );

  assign lap_valid   = ~lap_empty;
  assign lap_epoch   = {head.hour, head.minute, head.second};
  assign lap_m_epoch = head.m_sec;

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: directed self-checking bench, 4 kHz clock => 1 tick / 4 clk.
// Optional feature macro: STOPWATCH_DAY_COUNT_EN connects day.
module tb_stopwatch_lap;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        clear;
  logic        mode_down;
  logic        load;
  logic [17:0] load_epoch;
  logic [9:0]  load_m_epoch;
  logic        lap;
  logic [17:0] epoch;
  logic [9:0]  m_epoch;
  logic        wrap;
  logic        done;
  logic [17:0] lap_epoch;
  logic [9:0]  lap_m_epoch;
  logic        lap_valid;
  logic        lap_ready;
  logic        lap_overflow;
`ifdef STOPWATCH_DAY_COUNT_EN
  logic [7:0]  day;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  stopwatch_lap #(
    .CLK_FREQ_HZ (4000),
    .LAP_DEPTH   (4),
    .HOUR_MODULO (24)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .clear        (clear),
    .mode_down    (mode_down),
    .load         (load),
    .load_epoch   (load_epoch),
    .load_m_epoch (load_m_epoch),
    .lap          (lap),
    .epoch        (epoch),
    .m_epoch      (m_epoch),
    .wrap         (wrap),
    .done         (done),
    .lap_epoch    (lap_epoch),
    .lap_m_epoch  (lap_m_epoch),
    .lap_valid    (lap_valid),
    .lap_ready    (lap_ready),
    .lap_overflow (lap_overflow)
`ifdef STOPWATCH_DAY_COUNT_EN
    ,
    .day          (day)
`endif
  );

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {h[5:0], m[5:0], s[5:0]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input int h, input int m, input int s, input int ms);
    load_epoch   = hms(h, m, s);
    load_m_epoch = ms[9:0];
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    bit wrap_seen;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    run = 1'b1;
    step(20);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    step(16);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (epoch !== 18'd0 || m_epoch !== 10'd0) begin
      errors++;
      $display("FAIL reset_time got %h.%0d want 0.0", epoch, m_epoch);
    end
    checks++;
    if ({wrap, done, lap_valid, lap_overflow} !== 4'b0 ||
        lap_epoch !== 18'd0 || lap_m_epoch !== 10'd0) begin
      errors++;
      $display("FAIL reset_flags got w%b d%b v%b o%b head %h.%0d want zeros",
               wrap, done, lap_valid, lap_overflow, lap_epoch, lap_m_epoch);
    end
    @(negedge clock);
    reset_n = 1'b1;
    wrap_seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if (wrap) wrap_seen = 1'b1;
    end
    checks++;
    if (epoch !== hms(0, 0, 1) || m_epoch !== 10'd0) begin
      errors++;
      $display("FAIL run_1s got %h.%0d want %h.0", epoch, m_epoch, hms(0, 0, 1));
    end
    step(4);
    checks++;
    if (epoch !== hms(0, 0, 1) || m_epoch !== 10'd1) begin
      errors++;
      $display("FAIL run_1s_1ms got %h.%0d want %h.1", epoch, m_epoch, hms(0, 0, 1));
    end
    checks++;
    if (wrap_seen) begin
      errors++;
      $display("FAIL no_wrap got wrap=1 want never");
    end
    run = 1'b0;
  endtask

  task automatic test_saturate;
    do_load(63, 63, 63, 1023);
    checks++;
    if (epoch !== hms(23, 59, 59) || m_epoch !== 10'd999) begin
      errors++;
      $display("FAIL saturate got %h.%0d want %h.999", epoch, m_epoch, hms(23, 59, 59));
    end
    do_load(12, 60, 7, 1000);
    checks++;
    if (epoch !== hms(12, 59, 7) || m_epoch !== 10'd999) begin
      errors++;
      $display("FAIL saturate_mix got %h.%0d want %h.999", epoch, m_epoch, hms(12, 59, 7));
    end
  endtask

  task automatic test_up_wrap;
    mode_down = 1'b0;
    do_load(23, 59, 59, 998);
    run = 1'b1;
    step(4);
    checks++;
    if (epoch !== hms(23, 59, 59) || m_epoch !== 10'd999 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL up_999 got %h.%0d w%b want %h.999 w0", epoch, m_epoch, wrap, hms(23, 59, 59));
    end
    step(4);
    checks++;
    if (epoch !== 18'd0 || m_epoch !== 10'd0 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap got %h.%0d w%b want 0.0 w1", epoch, m_epoch, wrap);
    end
    step(1);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse got %b want 0", wrap);
    end
    step(3);
    checks++;
    if (epoch !== 18'd0 || m_epoch !== 10'd1) begin
      errors++;
      $display("FAIL up_after_wrap got %h.%0d want 0.1", epoch, m_epoch);
    end
    run = 1'b0;
  endtask

  task automatic test_down;
    logic [9:0] exp_ms [5] = '{10'd1, 10'd0, 10'd0, 10'd0, 10'd0};
    logic       exp_dn [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    mode_down = 1'b1;
    do_load(0, 0, 0, 2);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(4);
      checks++;
      if (epoch !== 18'd0 || m_epoch !== exp_ms[i] || done !== exp_dn[i]) begin
        errors++;
        $display("FAIL down_tick%0d got %h.%0d d%b want 0.%0d d%b",
                 i + 1, epoch, m_epoch, done, exp_ms[i], exp_dn[i]);
      end
    end
    run = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL clear_done got %b want 0", done);
    end
    mode_down = 1'b0;
  endtask

  task automatic test_lap_overflow;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    run = 1'b1;
    step(20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(19);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
    end
    run = 1'b0;
    checks++;
    if (lap_overflow !== 1'b1 || lap_valid !== 1'b1) begin
      errors++;
      $display("FAIL lap_ovf got o%b v%b want o1 v1", lap_overflow, lap_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (lap_valid !== 1'b1 || lap_epoch !== 18'd0 || lap_m_epoch !== 10'(5 * i)) begin
        errors++;
        $display("FAIL lap_pop%0d got v%b %h.%0d want v1 0.%0d",
                 i, lap_valid, lap_epoch, lap_m_epoch, 5 * i);
      end
      lap_ready = 1'b1;
      step(1);
      lap_ready = 1'b0;
    end
    checks++;
    if (lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL lap_drained got v%b want 0", lap_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_ms [4] = '{10'd101, 10'd102, 10'd103, 10'd200};
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    checks++;
    if (lap_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", lap_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      do_load(1, 2, 3, 100 + i);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
    end
    do_load(4, 5, 6, 200);
    lap = 1'b1;
    lap_ready = 1'b1;
    step(1);
    lap = 1'b0;
    lap_ready = 1'b0;
    checks++;
    if (lap_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_ovf got %b want 0", lap_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lap_valid !== 1'b1 || lap_m_epoch !== exp_ms[i] ||
          lap_epoch !== ((i == 3) ? hms(4, 5, 6) : hms(1, 2, 3))) begin
        errors++;
        $display("FAIL b2b_pop%0d got v%b %h.%0d want ms %0d",
                 i, lap_valid, lap_epoch, lap_m_epoch, exp_ms[i]);
      end
      lap_ready = 1'b1;
      step(1);
      lap_ready = 1'b0;
    end
    checks++;
    if (lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained got v%b want 0", lap_valid);
    end
  endtask

  task automatic test_clear_priority;
    lap_ready = 1'b1;
    step(1);
    lap_ready = 1'b0;
    do_load(10, 20, 30, 400);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    checks++;
    if (lap_valid !== 1'b1 || lap_epoch !== hms(10, 20, 30) || lap_m_epoch !== 10'd400) begin
      errors++;
      $display("FAIL empty_pop_then_push got v%b %h.%0d want v1 %h.400",
               lap_valid, lap_epoch, lap_m_epoch, hms(10, 20, 30));
    end
    mode_down = 1'b1;
    do_load(0, 0, 0, 0);
    run = 1'b1;
    step(4);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL prio_setup_done got %b want 1", done);
    end
    step(3);
    load_epoch   = hms(7, 8, 9);
    load_m_epoch = 10'd10;
    clear = 1'b1;
    load  = 1'b1;
    step(1);
    clear = 1'b0;
    load  = 1'b0;
    run   = 1'b0;
    checks++;
    if (epoch !== 18'd0 || m_epoch !== 10'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins got %h.%0d d%b want 0.0 d0", epoch, m_epoch, done);
    end
    checks++;
    if (lap_valid !== 1'b1 || lap_epoch !== hms(10, 20, 30) || lap_m_epoch !== 10'd400) begin
      errors++;
      $display("FAIL fifo_kept got v%b %h.%0d want v1 %h.400",
               lap_valid, lap_epoch, lap_m_epoch, hms(10, 20, 30));
    end
    step(8);
    checks++;
    if (epoch !== 18'd0 || m_epoch !== 10'd0) begin
      errors++;
      $display("FAIL paused_hold got %h.%0d want 0.0", epoch, m_epoch);
    end
    mode_down = 1'b0;
    lap_ready = 1'b1;
    step(1);
    lap_ready = 1'b0;
    checks++;
    if (lap_valid !== 1'b0) begin
      errors++;
      $display("FAIL final_pop got v%b want 0", lap_valid);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    run          = 1'b0;
    clear        = 1'b0;
    mode_down    = 1'b0;
    load         = 1'b0;
    load_epoch   = '0;
    load_m_epoch = '0;
    lap          = 1'b0;
    lap_ready    = 1'b0;
    test_reset();
    test_saturate();
    test_up_wrap();
    test_down();
    test_lap_overflow();
    test_back_to_back();
    test_clear_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
